// File: rtl/pal_macrocell_array.sv
// Reconfigurable PAL fabric: programmable AND plane, OR plane and per-output
// macrocells (combinational or registered, optional inversion), with optional
// register feedback into the AND plane. Configuration is shifted serially into
// a shadow register and copied to the active register by an atomic commit.
module pal_macrocell_array #(
    parameter int unsigned N        = 8,
    parameter int unsigned M        = 4,
    parameter int unsigned P        = 16,
    parameter int unsigned FEEDBACK = 0
) (
    input  logic         i_clk,
    input  logic         i_res,
    input  logic [N-1:0] i_in,
    output logic [M-1:0] o_out,
    input  logic         i_run_en,
    input  logic         i_cfg_valid,
    input  logic         i_cfg_in,
    input  logic         i_cfg_commit,
    output logic         o_cfg_out,
    output logic         o_configured,
    output logic         o_cfg_err
);

    // Literal count seen by the AND plane (primary inputs plus optional feedback)
    localparam int unsigned NI       = N + ((FEEDBACK != 0) ? M : 0);
    localparam int unsigned CFG_BITS = 2 * NI * P + M * P + 2 * M;
    localparam int unsigned A_BASE   = 2 * NI * P;
    localparam int unsigned B_BASE   = A_BASE + M * P;
    localparam int unsigned CNT_W    = $clog2(CFG_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        StUncfg,
        StRun
    } state_e;

    state_e               r_state;
    state_e               w_state_next;

    logic [CFG_BITS-1:0]  r_shadow;
    logic [CFG_BITS-1:0]  r_active;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic                 r_ovf;
    logic [M-1:0]         r_q;
    logic                 r_configured;
    logic                 r_cfg_err;

    logic [NI-1:0]        w_lit;
    logic [P-1:0]         w_pt;
    logic [M-1:0]         w_sum;
    logic [M-1:0]         w_c;
    logic [M-1:0]         w_reg_en;
    logic [M-1:0]         w_invert;
    logic                 w_commit_ok;
    logic                 w_commit_rej;

    // ------------------------------------------------------------------
    // Literal vector: {q, in} with feedback, otherwise just the inputs
    // ------------------------------------------------------------------
    if (FEEDBACK != 0) begin : g_fb
        assign w_lit = {r_q, i_in};
    end else begin : g_nofb
        assign w_lit = i_in;
    end

    // ------------------------------------------------------------------
    // AND plane: each term is the AND of its enabled literals; a term with
    // no enabled literal is forced to 0 rather than the empty-AND 1.
    // ------------------------------------------------------------------
    for (genvar p = 0; p < P; p++) begin : g_pt
        logic [NI-1:0] w_en_t;
        logic [NI-1:0] w_en_c;

        for (genvar i = 0; i < NI; i++) begin : g_lit
            assign w_en_t[i] = r_active[p * 2 * NI + 2 * i];
            assign w_en_c[i] = r_active[p * 2 * NI + 2 * i + 1];
        end

        assign w_pt[p] = (|(w_en_t | w_en_c))
                       & (&((~w_en_t | w_lit) & (~w_en_c | ~w_lit)));
    end

    // ------------------------------------------------------------------
    // OR plane and macrocell configuration decode
    // ------------------------------------------------------------------
    for (genvar m = 0; m < M; m++) begin : g_mc
        assign w_sum[m]    = |(w_pt & r_active[A_BASE + m * P +: P]);
        assign w_reg_en[m] = r_active[B_BASE + 2 * m];
        assign w_invert[m] = r_active[B_BASE + 2 * m + 1];
    end

    assign w_c = w_sum ^ w_invert;

    // Commit decisions use the pre-shift count of this cycle
    assign w_commit_ok  = i_cfg_commit && (r_bit_cnt == CNT_FULL) && !r_ovf;
    assign w_commit_rej = i_cfg_commit && !w_commit_ok;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_state <= StUncfg;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: any accepted commit enters RUN; nothing leaves it except reset
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StUncfg: if (w_commit_ok) w_state_next = StRun;
            StRun:   w_state_next = StRun;
            default: w_state_next = StUncfg;
        endcase
    end

    // Outputs: forced low until configured, otherwise per-macrocell select
    always_comb begin
        o_out = '0;
        if (r_state == StRun) begin
            o_out = (w_reg_en & r_q) | (~w_reg_en & w_c);
        end
    end

    // ------------------------------------------------------------------
    // Configuration path
    // ------------------------------------------------------------------

    // Shadow shift register; untouched by commit
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_shadow <= '0;
        end else if (i_cfg_valid) begin
            r_shadow <= {r_shadow[CFG_BITS-2:0], i_cfg_in};
        end
    end

    // Bit counter and overflow flag; a shift coinciding with a commit is
    // counted as the first bit of the next load
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_bit_cnt <= '0;
            r_ovf     <= 1'b0;
        end else if (i_cfg_commit) begin
            r_bit_cnt <= i_cfg_valid ? CNT_ONE : '0;
            r_ovf     <= 1'b0;
        end else if (i_cfg_valid) begin
            if (r_bit_cnt == CNT_FULL) begin
                r_ovf <= 1'b1;
            end else begin
                r_bit_cnt <= r_bit_cnt + CNT_ONE;
            end
        end
    end

    // Active configuration is loaded only by an accepted commit
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_active <= '0;
        end else if (w_commit_ok) begin
            r_active <= r_shadow;
        end
    end

    // Status flags: sticky configured, one-cycle error pulse on rejection
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_configured <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            if (w_commit_ok) begin
                r_configured <= 1'b1;
            end
            r_cfg_err <= w_commit_rej;
        end
    end

    // ------------------------------------------------------------------
    // Macrocell registers
    // ------------------------------------------------------------------

    // Cleared on commit, held at 0 until RUN, then gated by run_en
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_q <= '0;
        end else if (w_commit_ok) begin
            r_q <= '0;
        end else if ((r_state == StRun) && i_run_en) begin
            r_q <= w_c;
        end
    end

    assign o_cfg_out    = r_shadow[CFG_BITS-1];
    assign o_configured = r_configured;
    assign o_cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_pal_macrocell_array.sv
// Scoreboard bench for pal_macrocell_array: two small instances, one without
// and one with register feedback. Stimulus pushes expected values; a monitor
// on the falling edge pops and compares them.
module tb_pal_macrocell_array;

    localparam int SEL_OUT0  = 0;
    localparam int SEL_CFGD0 = 1;
    localparam int SEL_ERR0  = 2;
    localparam int SEL_CO0   = 3;
    localparam int SEL_OUT1  = 4;
    localparam int SEL_ERR1  = 5;
    localparam int SEL_CFGD1 = 6;

    typedef struct {
        string      name;
        int         sel;
        logic [1:0] exp;
    } chk_t;

    chk_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic       clk = 1'b0;
    logic       res;
    logic [3:0] in0, in1;
    logic [1:0] out0, out1;
    logic       run0, cv0, ci0, cc0, co0, cfgd0, err0;
    logic       run1, cv1, ci1, cc1, co1, cfgd1, err1;

    logic [63:0] cfg_a, cfg_b, cfg_f;

    always #5 clk = ~clk;

    pal_macrocell_array #(.N(4), .M(2), .P(4), .FEEDBACK(0)) u_dut0 (
        .i_clk        (clk),
        .i_res        (res),
        .i_in         (in0),
        .o_out        (out0),
        .i_run_en     (run0),
        .i_cfg_valid  (cv0),
        .i_cfg_in     (ci0),
        .i_cfg_commit (cc0),
        .o_cfg_out    (co0),
        .o_configured (cfgd0),
        .o_cfg_err    (err0)
    );

    pal_macrocell_array #(.N(4), .M(2), .P(4), .FEEDBACK(1)) u_dut1 (
        .i_clk        (clk),
        .i_res        (res),
        .i_in         (in1),
        .o_out        (out1),
        .i_run_en     (run1),
        .i_cfg_valid  (cv1),
        .i_cfg_in     (ci1),
        .i_cfg_commit (cc1),
        .o_cfg_out    (co1),
        .o_configured (cfgd1),
        .o_cfg_err    (err1)
    );

    // Monitor: compare every pending expectation at the falling edge
    always @(negedge clk) begin
        chk_t       e;
        logic [1:0] act;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            case (e.sel)
                SEL_OUT0:  act = out0;
                SEL_CFGD0: act = {1'b0, cfgd0};
                SEL_ERR0:  act = {1'b0, err0};
                SEL_CO0:   act = {1'b0, co0};
                SEL_OUT1:  act = out1;
                SEL_ERR1:  act = {1'b0, err1};
                SEL_CFGD1: act = {1'b0, cfgd1};
                default:   act = 2'bxx;
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %b expected %b at %0t", e.name, act, e.exp, $time);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input string name, input int sel, input logic [1:0] v);
        chk_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = v;
        sb.push_back(e);
    endtask

    // Shift v[n-1] first; optionally check out0 holds while shifting
    task automatic shift(input int which, input logic [63:0] v, input int n,
                         input int chk_at, input logic [1:0] hold);
        for (int k = n - 1; k >= 0; k--) begin
            if (which == 0) begin
                cv0 = 1'b1;
                ci0 = v[k];
            end else begin
                cv1 = 1'b1;
                ci1 = v[k];
            end
            if (k == chk_at) expect_v("shift_hold_out0", SEL_OUT0, hold);
            step();
        end
        cv0 = 1'b0; ci0 = 1'b0;
        cv1 = 1'b0; ci1 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // NI=4, P=4: term p literal i true at 8p+2i; OR base 32; macrocell base 40
        cfg_a = '0;
        cfg_a[0]  = 1'b1;  // term0 in0
        cfg_a[2]  = 1'b1;  // term0 in1
        cfg_a[12] = 1'b1;  // term1 in2
        cfg_a[32] = 1'b1;  // out0 <- term0
        cfg_a[37] = 1'b1;  // out1 <- term1
        cfg_a[42] = 1'b1;  // out1 registered
        cfg_a[43] = 1'b1;  // out1 inverted

        cfg_b = '0;
        cfg_b[7]  = 1'b1;  // term0 ~in3
        cfg_b[18] = 1'b1;  // term2 in1
        cfg_b[32] = 1'b1;  // out0 <- term0
        cfg_b[38] = 1'b1;  // out1 <- term2
        cfg_b[42] = 1'b1;  // out1 registered

        // NI=6: q0 is literal 4; OR base 48; macrocell base 56
        cfg_f = '0;
        cfg_f[9]  = 1'b1;  // term0 ~q0
        cfg_f[48] = 1'b1;  // out0 <- term0
        cfg_f[56] = 1'b1;  // out0 registered

        // Reset held two edges with shift and commit asserted
        res = 1'b1;
        in0 = 4'hF; run0 = 1'b0; cv0 = 1'b1; ci0 = 1'b1; cc0 = 1'b1;
        in1 = 4'h0; run1 = 1'b0; cv1 = 1'b1; ci1 = 1'b1; cc1 = 1'b1;
        step();
        expect_v("rst_out0", SEL_OUT0, 2'b00);
        expect_v("rst_cfgd0", SEL_CFGD0, 2'b00);
        expect_v("rst_cfgout0", SEL_CO0, 2'b00);
        expect_v("rst_err0", SEL_ERR0, 2'b00);
        expect_v("rst_out1", SEL_OUT1, 2'b00);
        expect_v("rst_cfgd1", SEL_CFGD1, 2'b00);
        step();
        res = 1'b0;
        cv0 = 1'b0; ci0 = 1'b0; cc0 = 1'b0;
        cv1 = 1'b0; ci1 = 1'b0; cc1 = 1'b0;
        expect_v("post_rst_out0", SEL_OUT0, 2'b00);
        expect_v("post_rst_cfgout0", SEL_CO0, 2'b00);
        expect_v("post_rst_err0", SEL_ERR0, 2'b00);
        step();

        // Load config A; outputs stay low until commit
        shift(0, cfg_a, 44, -1, 2'b00);
        in0 = 4'b0011; cc0 = 1'b1;
        expect_v("loaded_cfgout0", SEL_CO0, 2'b01);
        expect_v("uncfg_out0", SEL_OUT0, 2'b00);
        expect_v("uncfg_cfgd0", SEL_CFGD0, 2'b00);
        step();
        cc0 = 1'b0;
        expect_v("commit_cfgd0", SEL_CFGD0, 2'b01);
        expect_v("commit_err0", SEL_ERR0, 2'b00);
        expect_v("comb_and_hit", SEL_OUT0, 2'b01);
        step();
        in0 = 4'b0001;
        expect_v("comb_and_miss", SEL_OUT0, 2'b00);
        step();

        // Registered inverted out1 = ~in2
        run0 = 1'b1;
        expect_v("reg_before_edge", SEL_OUT0, 2'b00);
        step();
        in0 = 4'b0101;
        expect_v("reg_rise", SEL_OUT0, 2'b10);
        step();
        run0 = 1'b0; in0 = 4'b0001;
        expect_v("reg_fall", SEL_OUT0, 2'b00);
        step();
        expect_v("reg_hold", SEL_OUT0, 2'b00);
        step();
        run0 = 1'b1;
        expect_v("reg_hold2", SEL_OUT0, 2'b00);
        step();
        run0 = 1'b0; in0 = 4'b0011;
        expect_v("reg_reenable", SEL_OUT0, 2'b11);

        // Short load rejected
        shift(0, cfg_a, 43, -1, 2'b00);
        cc0 = 1'b1;
        expect_v("short_pre", SEL_OUT0, 2'b11);
        step();
        cc0 = 1'b0;
        expect_v("short_err", SEL_ERR0, 2'b01);
        expect_v("short_keep", SEL_OUT0, 2'b11);
        expect_v("short_cfgd", SEL_CFGD0, 2'b01);
        step();
        expect_v("short_err_drop", SEL_ERR0, 2'b00);

        // Overlong load rejected
        shift(0, cfg_a, 45, -1, 2'b00);
        cc0 = 1'b1;
        step();
        cc0 = 1'b0;
        expect_v("long_err", SEL_ERR0, 2'b01);
        expect_v("long_keep", SEL_OUT0, 2'b11);
        step();
        expect_v("long_err_drop", SEL_ERR0, 2'b00);

        // Reload B while running; function unchanged during shift
        in0 = 4'b1011;
        expect_v("a_1011", SEL_OUT0, 2'b11);
        shift(0, cfg_b, 44, 20, 2'b11);
        cc0 = 1'b1;
        expect_v("b_loaded_cfgout0", SEL_CO0, 2'b00);
        expect_v("b_pre_commit", SEL_OUT0, 2'b11);
        step();
        cc0 = 1'b0; run0 = 1'b1;
        expect_v("b_commit_out", SEL_OUT0, 2'b00);
        expect_v("b_commit_err", SEL_ERR0, 2'b00);
        step();
        run0 = 1'b0;
        expect_v("b_reg_rise", SEL_OUT0, 2'b10);
        step();

        // Commit with a simultaneous shift: accepted, and that bit starts the next load
        shift(0, cfg_a, 44, -1, 2'b00);
        cc0 = 1'b1; cv0 = 1'b1; ci0 = cfg_a[43];
        expect_v("combo_pre", SEL_OUT0, 2'b10);
        step();
        cc0 = 1'b0; cv0 = 1'b0; ci0 = 1'b0;
        expect_v("combo_err", SEL_ERR0, 2'b00);
        expect_v("combo_out", SEL_OUT0, 2'b01);
        step();
        shift(0, cfg_a, 43, -1, 2'b00);
        cc0 = 1'b1;
        step();
        cc0 = 1'b0;
        expect_v("combo_next_err", SEL_ERR0, 2'b00);
        expect_v("combo_next_cfgout", SEL_CO0, 2'b01);
        expect_v("combo_next_out", SEL_OUT0, 2'b01);
        step();

        // Feedback instance: out0 = reg(~q0) toggles each enabled edge
        shift(1, cfg_f, 60, -1, 2'b00);
        run1 = 1'b1; cc1 = 1'b1;
        expect_v("fb_pre", SEL_OUT1, 2'b00);
        step();
        cc1 = 1'b0;
        expect_v("fb_cfgd", SEL_CFGD1, 2'b01);
        expect_v("fb_err", SEL_ERR1, 2'b00);
        expect_v("fb_t0", SEL_OUT1, 2'b00);
        step();
        expect_v("fb_t1", SEL_OUT1, 2'b01);
        step();
        expect_v("fb_t2", SEL_OUT1, 2'b00);
        step();
        run1 = 1'b0;
        expect_v("fb_t3", SEL_OUT1, 2'b01);
        step();
        expect_v("fb_hold", SEL_OUT1, 2'b01);
        step();

        for (int i = 0; i < 10 && sb.size() != 0; i++) step();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
